count_enable_mc: RTL

Multi-channel, runtime-programmable clock-enable (tick) generator; successor to the single fixed-divisor counter enable. Each channel divides i_clk by its own divisor, can run free-running or one-shot, and can be phase-resynchronised by selected edges of the shared control-path edge bus. Sits beside the counter pipeline and feeds per-channel count enables to counter/sampler stages.

---
 rtl/count_enable_mc_pkg.sv | 33 +++
 rtl/count_enable_ch.sv | 88 ++++++++
 rtl/count_enable_mc.sv | 40 ++++
 3 files changed

// File: rtl/count_enable_mc_pkg.sv
// Shared types for the multi-channel tick generator: channel modes, resync selects,
// channel FSM states and the control-path edge strobe bundle.
package count_enable_mc_pkg;

  typedef enum logic {
    MODE_FREE    = 1'b0,
    MODE_ONESHOT = 1'b1
  } tick_mode_e;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_RISE = 2'd1,
    RS_FALL = 2'd2,
    RS_BOTH = 2'd3
  } resync_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_ch_state_e;

  typedef struct packed {
    logic rising;
    logic falling;
  } edges_t;

  function automatic logic resync_hit(input edges_t e, input resync_sel_e sel);
    return (e.rising  && (sel == RS_RISE || sel == RS_BOTH)) ||
           (e.falling && (sel == RS_FALL || sel == RS_BOTH));
  endfunction

endpackage

// File: rtl/count_enable_ch.sv
// One tick channel: divides i_clk by a divisor latched at period boundaries, free or one-shot.
// All outputs registered, one cycle after the inputs that cause them; never stalls.
module count_enable_ch
  import count_enable_mc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  edges_t            edges,
  input  logic              enable,
  input  tick_mode_e        mode,
  input  resync_sel_e       resync_sel,
  input  logic [CNT_W-1:0]  div,
  output logic              tick,
  output logic [CNT_W-1:0]  count,
  output logic              done
);

  tick_ch_state_e   state;
  tick_mode_e       mode_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_eff;
  logic             resync;
  logic             wrap;

  // Divisors 0 and 1 both mean "tick every cycle".
  assign div_eff = (div <= CNT_W'(1)) ? CNT_W'(1) : div;
  assign resync  = resync_hit(edges, resync_sel);
  assign wrap    = (count == div_q - CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      count  <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      mode_q <= MODE_FREE;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        count <= '0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= RUN;
            count  <= '0;
            div_q  <= div_eff;
            mode_q <= mode;
          end
          RUN, DONE: begin
            // A resync restarts the period and beats a coincident wrap.
            if (resync) begin
              state  <= RUN;
              count  <= '0;
              done   <= 1'b0;
              div_q  <= div_eff;
              mode_q <= mode;
            end else if (state == RUN) begin
              if (wrap) begin
                count  <= '0;
                tick   <= 1'b1;
                div_q  <= div_eff;
                mode_q <= mode;
                if (mode_q == MODE_ONESHOT) begin
                  state <= DONE;
                  done  <= 1'b1;
                end
              end else begin
                count <= count + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/count_enable_mc.sv
// Multi-channel programmable clock-enable generator; channels are independent and share i_edges.
// Outputs registered per channel, one cycle after inputs; no backpressure.
module count_enable_mc
  import count_enable_mc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  edges_t                         i_edges,
  input  logic [NUM_CH-1:0]              i_enable,
  input  tick_mode_e [NUM_CH-1:0]        i_mode,
  input  resync_sel_e [NUM_CH-1:0]       i_resync_sel,
  input  logic [NUM_CH-1:0][CNT_W-1:0]   i_div,
  output logic [NUM_CH-1:0]              o_tick,
  output logic [NUM_CH-1:0][CNT_W-1:0]   o_count,
  output logic [NUM_CH-1:0]              o_done
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    count_enable_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .edges      (i_edges),
      .enable     (i_enable[g]),
      .mode       (i_mode[g]),
      .resync_sel (i_resync_sel[g]),
      .div        (i_div[g]),
      .tick       (o_tick[g]),
      .count      (o_count[g]),
      .done       (o_done[g])
    );
  end

endmodule
